// File: rtl/max_exp_group_seq.sv
// ---------------------------------------------------------------------------
// max_exp_group_seq
//   Sequential max-exponent finder used for block-floating-point alignment
//   ahead of the MAC array. One exponent per accepted beat goes through a
//   single shared comparator/mux pair. After GROUP_SIZE beats the group
//   maximum is presented on o_max_exp with o_valid. The result is held
//   until downstream takes it. This trades throughput (one group per
//   GROUP_SIZE+1 cycles at best) for the area of an unrolled compare tree.
//
// Parameters
//   EXP_W       exponent width, compared as an unsigned number
//   GROUP_SIZE  elements per group, 1..255
//   CNT_W       element counter width, 2**CNT_W > GROUP_SIZE
//
// Ports
//   i_clk      in   1      clock, rising edge
//   i_rst_n    in   1      asynchronous active-low reset
//   i_clear    in   1      synchronous abort of the current group/result
//   i_valid    in   1      upstream exponent valid
//   o_ready    out  1      an exponent can be accepted this cycle
//   i_exp      in   EXP_W  exponent beat
//   o_valid    out  1      group result valid (registered)
//   i_ready    in   1      downstream accepts the result
//   o_max_exp  out  EXP_W  maximum exponent of the last completed group
//   o_count    out  CNT_W  elements accepted so far in the current group
//   o_busy     out  1      group in progress or result pending
// ---------------------------------------------------------------------------
module max_exp_group_seq #(
  parameter int EXP_W      = 6,
  parameter int GROUP_SIZE = 9,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [EXP_W-1:0] i_exp,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [EXP_W-1:0] o_max_exp,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Counter value of the beat that closes a group.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GROUP_SIZE - 1);

  // First beat of a group loads unconditionally; afterwards only a strictly
  // larger exponent replaces the running max, so ties keep the old value.
  function automatic logic [EXP_W-1:0] max_sel(
    input logic [EXP_W-1:0] cur,
    input logic [EXP_W-1:0] cand,
    input logic             first
  );
    logic [EXP_W-1:0] res;
    if (first)
      res = cand;
    else if (cand > cur)
      res = cand;
    else
      res = cur;
    return res;
  endfunction

  state_t           state_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [EXP_W-1:0] run_max_p0;
  logic [EXP_W-1:0] max_exp_p0;
  logic             vld_p0;

  logic             accept;
  logic             last_beat;
  logic [EXP_W-1:0] next_max;

  always_comb begin
    accept    = 1'b0;
    last_beat = 1'b0;
    next_max  = run_max_p0;
    accept    = i_valid && (state_p0 == ACCUM);
    last_beat = (cnt_p0 == LAST_IDX);
    next_max  = max_sel(run_max_p0, i_exp, (cnt_p0 == '0));
  end

  // ---- stage p0: accumulate / hold result ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_p0   <= ACCUM;
      cnt_p0     <= '0;
      run_max_p0 <= '0;
      max_exp_p0 <= '0;
      vld_p0     <= 1'b0;
    end else if (i_clear) begin
      // Abort wins over a same-cycle beat or result handshake; the last
      // published maximum is deliberately left in place.
      state_p0 <= ACCUM;
      cnt_p0   <= '0;
      vld_p0   <= 1'b0;
    end else begin
      case (state_p0)
        ACCUM: begin
          if (accept) begin
            run_max_p0 <= next_max;
            if (last_beat) begin
              state_p0   <= DONE;
              cnt_p0     <= '0;
              max_exp_p0 <= next_max;
              vld_p0     <= 1'b1;
            end else begin
              cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            state_p0 <= ACCUM;
            vld_p0   <= 1'b0;
          end
        end
        default: begin
          state_p0 <= ACCUM;
          cnt_p0   <= '0;
          vld_p0   <= 1'b0;
        end
      endcase
    end
  end

  // ---- outputs: registered result, state decodes ----
  assign o_valid   = vld_p0;
  assign o_max_exp = max_exp_p0;
  assign o_count   = cnt_p0;
  assign o_ready   = (state_p0 == ACCUM);
  assign o_busy    = (cnt_p0 != '0) || vld_p0;

endmodule

// File: tb/tb_max_exp_group_seq.sv
module tb_max_exp_group_seq;

  localparam int EXP_W = 6;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             valid;
  logic             rdy;
  logic [EXP_W-1:0] exp_in;
  logic             vld;
  logic             ds_ready;
  logic [EXP_W-1:0] max_exp;
  logic [CNT_W-1:0] count;
  logic             busy;

  logic             clear1;
  logic             valid1;
  logic             rdy1;
  logic [EXP_W-1:0] exp1;
  logic             vld1;
  logic             ds_ready1;
  logic [EXP_W-1:0] max_exp1;
  logic [CNT_W-1:0] count1;
  logic             busy1;

  int n_pass;
  int n_total;

  max_exp_group_seq #(.EXP_W(EXP_W), .GROUP_SIZE(9), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid),
    .o_ready(rdy), .i_exp(exp_in), .o_valid(vld), .i_ready(ds_ready),
    .o_max_exp(max_exp), .o_count(count), .o_busy(busy)
  );

  max_exp_group_seq #(.EXP_W(EXP_W), .GROUP_SIZE(1), .CNT_W(CNT_W)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear1), .i_valid(valid1),
    .o_ready(rdy1), .i_exp(exp1), .o_valid(vld1), .i_ready(ds_ready1),
    .o_max_exp(max_exp1), .o_count(count1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat (after an idle gap) and let it be accepted.
  task automatic feed(input logic [EXP_W-1:0] v, input int gap);
    valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    valid  = 1'b1;
    exp_in = v;
    tick();
    valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; valid = 1'b0; exp_in = '0; ds_ready = 1'b0;
    clear1 = 1'b0; valid1 = 1'b0; exp1 = '0; ds_ready1 = 1'b0;
    #12;
    n_total++; if (rdy !== 1'b1) $display("FAIL reset_ready got %0b want 1", rdy); else n_pass++;
    n_total++; if (vld !== 1'b0) $display("FAIL reset_valid got %0b want 0", vld); else n_pass++;
    n_total++; if (count !== 8'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (max_exp !== 6'd0) $display("FAIL reset_max got %0d want 0", max_exp); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // T1: 3,7,1,12,12,5,0,9,2 back-to-back -> 12
  task automatic test_basic();
    logic [EXP_W-1:0] beats [9];
    beats = '{6'd3, 6'd7, 6'd1, 6'd12, 6'd12, 6'd5, 6'd0, 6'd9, 6'd2};
    ds_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1;
      exp_in = beats[i];
      tick();
      if (i < 8) begin
        n_total++;
        if (count !== 8'(i + 1) || vld !== 1'b0 || rdy !== 1'b1)
          $display("FAIL basic_count beat %0d got cnt=%0d vld=%0b rdy=%0b want cnt=%0d vld=0 rdy=1",
                   i, count, vld, rdy, i + 1);
        else n_pass++;
      end
    end
    valid = 1'b0;
    n_total++; if (vld !== 1'b1) $display("FAIL basic_valid got %0b want 1", vld); else n_pass++;
    n_total++; if (max_exp !== 6'd12) $display("FAIL basic_max got %0d want 12", max_exp); else n_pass++;
    n_total++; if (rdy !== 1'b0) $display("FAIL basic_ready got %0b want 0", rdy); else n_pass++;
    n_total++; if (count !== 8'd0 || busy !== 1'b1)
      $display("FAIL basic_done_cnt got cnt=%0d busy=%0b want 0/1", count, busy); else n_pass++;
  endtask

  // T2: stall in DONE with junk on the input, then a clean next group
  task automatic test_stall_done();
    valid = 1'b1; exp_in = 6'd63; ds_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (vld !== 1'b1 || max_exp !== 6'd12 || count !== 8'd0 || rdy !== 1'b0)
        $display("FAIL stall_hold cyc %0d got vld=%0b max=%0d cnt=%0d rdy=%0b want 1/12/0/0",
                 i, vld, max_exp, count, rdy);
      else n_pass++;
    end
    valid = 1'b0; ds_ready = 1'b1;
    tick();
    ds_ready = 1'b0;
    n_total++; if (vld !== 1'b0 || rdy !== 1'b1 || count !== 8'd0)
      $display("FAIL stall_release got vld=%0b rdy=%0b cnt=%0d want 0/1/0", vld, rdy, count);
    else n_pass++;
    feed(6'd4, 0);
    for (int i = 0; i < 8; i++) feed(6'd1, 0);
    n_total++; if (vld !== 1'b1 || max_exp !== 6'd4)
      $display("FAIL stall_next got vld=%0b max=%0d want 1/4", vld, max_exp);
    else n_pass++;
    ds_ready = 1'b1; tick(); ds_ready = 1'b0;
  endtask

  // Extreme exponents: all-zero group and a single all-ones beat at the end
  task automatic test_extremes();
    for (int i = 0; i < 9; i++) feed(6'd0, 0);
    n_total++; if (vld !== 1'b1 || max_exp !== 6'd0)
      $display("FAIL extreme_zero got vld=%0b max=%0d want 1/0", vld, max_exp);
    else n_pass++;
    ds_ready = 1'b1; tick(); ds_ready = 1'b0;
    for (int i = 0; i < 8; i++) feed(6'd62 - 6'(i), 0);
    feed(6'd63, 0);
    n_total++; if (vld !== 1'b1 || max_exp !== 6'd63)
      $display("FAIL extreme_ones got vld=%0b max=%0d want 1/63", vld, max_exp);
    else n_pass++;
    ds_ready = 1'b1; tick(); ds_ready = 1'b0;
  endtask

  // T3: 100 random groups with random input gaps and result back-pressure
  task automatic test_random();
    logic [EXP_W-1:0] v;
    logic [EXP_W-1:0] ref_max;
    for (int g = 0; g < 100; g++) begin
      ref_max = '0;
      for (int i = 0; i < 9; i++) begin
        v = EXP_W'($urandom_range(0, 63));
        if (v > ref_max) ref_max = v;
        feed(v, int'($urandom_range(0, 2)));
      end
      n_total++; if (vld !== 1'b1 || max_exp !== ref_max)
        $display("FAIL random_max grp %0d got vld=%0b max=%0d want 1/%0d", g, vld, max_exp, ref_max);
      else n_pass++;
      valid = 1'b1; exp_in = 6'd63;
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
      ds_ready = 1'b1;
      tick();
      ds_ready = 1'b0; valid = 1'b0;
      n_total++; if (vld !== 1'b0 || count !== 8'd0)
        $display("FAIL random_handoff grp %0d got vld=%0b cnt=%0d want 0/0", g, vld, count);
      else n_pass++;
    end
  endtask

  // T4: clear mid-group, and clear colliding with a result handshake
  task automatic test_clear();
    feed(6'd10, 0); feed(6'd40, 0); feed(6'd3, 0); feed(6'd7, 0); feed(6'd20, 0);
    n_total++; if (count !== 8'd5) $display("FAIL clear_pre_cnt got %0d want 5", count); else n_pass++;
    clear = 1'b1; valid = 1'b1; exp_in = 6'd50;
    tick();
    clear = 1'b0; valid = 1'b0;
    n_total++; if (count !== 8'd0 || busy !== 1'b0 || vld !== 1'b0)
      $display("FAIL clear_abort got cnt=%0d busy=%0b vld=%0b want 0/0/0", count, busy, vld);
    else n_pass++;
    for (int i = 0; i < 9; i++) feed(6'd2, 0);
    n_total++; if (vld !== 1'b1 || max_exp !== 6'd2)
      $display("FAIL clear_result got vld=%0b max=%0d want 1/2", vld, max_exp);
    else n_pass++;
    clear = 1'b1; ds_ready = 1'b1;
    tick();
    clear = 1'b0; ds_ready = 1'b0;
    n_total++; if (vld !== 1'b0 || max_exp !== 6'd2 || rdy !== 1'b1)
      $display("FAIL clear_done got vld=%0b max=%0d rdy=%0b want 0/2/1", vld, max_exp, rdy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (vld !== 1'b0 || count !== 8'd0)
        $display("FAIL clear_no_extra cyc %0d got vld=%0b cnt=%0d want 0/0", i, vld, count);
      else n_pass++;
    end
  endtask

  // T5: asynchronous reset mid-group and mid-DONE
  task automatic test_async_reset();
    feed(6'd60, 0);
    for (int i = 0; i < 5; i++) feed(6'd30, 0);
    n_total++; if (count !== 8'd6) $display("FAIL areset_pre_cnt got %0d want 6", count); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (count !== 8'd0 || busy !== 1'b0 || rdy !== 1'b1 || max_exp !== 6'd0 || vld !== 1'b0)
      $display("FAIL areset_group got cnt=%0d busy=%0b rdy=%0b max=%0d vld=%0b want 0/0/1/0/0",
               count, busy, rdy, max_exp, vld);
    else n_pass++;
    #3 rst_n = 1'b1;
    tick();
    feed(6'd5, 0);
    for (int i = 0; i < 8; i++) feed(6'd1, 0);
    n_total++; if (vld !== 1'b1 || max_exp !== 6'd5)
      $display("FAIL areset_fresh got vld=%0b max=%0d want 1/5", vld, max_exp);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (vld !== 1'b0 || max_exp !== 6'd0 || rdy !== 1'b1)
      $display("FAIL areset_done got vld=%0b max=%0d rdy=%0b want 0/0/1", vld, max_exp, rdy);
    else n_pass++;
    #3 rst_n = 1'b1;
    ds_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ds_ready = 1'b0;
    n_total++; if (vld !== 1'b0 || count !== 8'd0)
      $display("FAIL areset_no_out got vld=%0b cnt=%0d want 0/0", vld, count);
    else n_pass++;
  endtask

  // T6: GROUP_SIZE=1 instance, continuous valid and ready
  task automatic test_group_one();
    logic [EXP_W-1:0] vals [3];
    vals = '{6'd0, 6'd63, 6'd31};
    ds_ready1 = 1'b1; valid1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp1 = vals[i];
      tick();
      n_total++; if (vld1 !== 1'b1 || max_exp1 !== vals[i] || rdy1 !== 1'b0)
        $display("FAIL gs1_result %0d got vld=%0b max=%0d rdy=%0b want 1/%0d/0",
                 i, vld1, max_exp1, rdy1, vals[i]);
      else n_pass++;
      if (i < 2) exp1 = vals[i + 1];
      tick();
      n_total++; if (vld1 !== 1'b0 || rdy1 !== 1'b1)
        $display("FAIL gs1_gap %0d got vld=%0b rdy=%0b want 0/1", i, vld1, rdy1);
      else n_pass++;
    end
    valid1 = 1'b0; ds_ready1 = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_stall_done();
    test_extremes();
    test_random();
    test_clear();
    test_async_reset();
    test_group_one();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
